// File: rtl/config_frame_loader.sv
// rtl/config_frame_loader.sv - sync-detecting config stream loader driving frame-latch data and one-hot strobes
module config_frame_loader #(
  parameter int          FrameBitsPerRow = 32,
  parameter int          MaxFramesPerCol = 20,
  parameter int          NumberOfRows    = 4,
  parameter int          NumberOfCols    = 4,
  parameter int          StrobeCycles    = 2,
  parameter logic [31:0] SyncWord        = 32'hFAB0_FAB1
) (
  input  logic                                    CLK,
  input  logic                                    resetn,
  input  logic [FrameBitsPerRow-1:0]              s_data,
  input  logic                                    s_valid,
  output logic                                    s_ready,
  output logic [FrameBitsPerRow*NumberOfRows-1:0] FrameData,
  output logic [MaxFramesPerCol*NumberOfCols-1:0] FrameStrobe,
  output logic                                    ConfigBusy,
  output logic                                    ConfigError
);

  localparam int NumStrobes = MaxFramesPerCol * NumberOfCols;
  localparam int RW = (NumberOfRows > 1) ? $clog2(NumberOfRows) : 1;
  localparam int SW = (StrobeCycles > 1) ? $clog2(StrobeCycles) : 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] HEADER = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STROBE = 3'd3;
  localparam logic [2:0] HOLD   = 3'd4;

  logic [2:0]                              state_q, state_d;
  logic [FrameBitsPerRow*NumberOfRows-1:0] frame_data_q, frame_data_d;
  logic [NumStrobes-1:0]                   strobe_q, strobe_d;
  logic                                    error_q, error_d;
  logic                                    skip_q, skip_d;
  logic [RW-1:0]                           row_q, row_d;
  logic [SW-1:0]                           scnt_q, scnt_d;
  logic [7:0]                              col_q, col_d;
  logic [7:0]                              frame_q, frame_d;

  logic                  xfer;
  logic                  hdr_bad;
  logic [15:0]           strobe_idx;
  logic [NumStrobes-1:0] onehot;

  assign s_ready     = (state_q == IDLE) || (state_q == HEADER) || (state_q == DATA);
  assign xfer        = s_valid && s_ready;
  assign FrameData   = frame_data_q;
  assign FrameStrobe = strobe_q;
  assign ConfigBusy  = (state_q != IDLE);
  assign ConfigError = error_q;

  assign hdr_bad = ({24'b0, s_data[23:16]} >= 32'(NumberOfCols)) ||
                   ({24'b0, s_data[7:0]}   >= 32'(MaxFramesPerCol));

  // Only reached with in-range col/frame, so exactly one line decodes.
  assign strobe_idx = 16'(col_q) * 16'(MaxFramesPerCol) + 16'(frame_q);

  always_comb begin
    onehot = '0;
    for (int i = 0; i < NumStrobes; i++) begin
      onehot[i] = (strobe_idx == 16'(i));
    end
  end

  always_comb begin
    state_d      = state_q;
    frame_data_d = frame_data_q;
    strobe_d     = strobe_q;
    error_d      = error_q;
    skip_d       = skip_q;
    row_d        = row_q;
    scnt_d       = scnt_q;
    col_d        = col_q;
    frame_d      = frame_q;
    case (state_q)
      IDLE: begin
        if (xfer && (s_data == SyncWord)) begin
          state_d = HEADER;
          error_d = 1'b0;
        end
      end
      HEADER: begin
        if (xfer) begin
          if (s_data[31]) begin
            state_d = IDLE;
          end else begin
            col_d   = s_data[23:16];
            frame_d = s_data[7:0];
            row_d   = '0;
            skip_d  = hdr_bad;
            state_d = DATA;
            if (hdr_bad) error_d = 1'b1;
          end
        end
      end
      DATA: begin
        if (xfer) begin
          for (int r = 0; r < NumberOfRows; r++) begin
            if (row_q == RW'(r)) frame_data_d[r*FrameBitsPerRow +: FrameBitsPerRow] = s_data;
          end
          if (row_q == RW'(NumberOfRows - 1)) begin
            row_d = '0;
            if (skip_q) begin
              state_d = HEADER;
            end else begin
              state_d  = STROBE;
              strobe_d = onehot;
              scnt_d   = '0;
            end
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      STROBE: begin
        if (scnt_q == SW'(StrobeCycles - 1)) begin
          strobe_d = '0;
          scnt_d   = '0;
          state_d  = HOLD;
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end
      HOLD:    state_d = HEADER;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      frame_data_q <= '0;
      strobe_q     <= '0;
      error_q      <= 1'b0;
      skip_q       <= 1'b0;
      row_q        <= '0;
      scnt_q       <= '0;
      col_q        <= '0;
      frame_q      <= '0;
    end else begin
      state_q      <= state_d;
      frame_data_q <= frame_data_d;
      strobe_q     <= strobe_d;
      error_q      <= error_d;
      skip_q       <= skip_d;
      row_q        <= row_d;
      scnt_q       <= scnt_d;
      col_q        <= col_d;
      frame_q      <= frame_d;
    end
  end

endmodule

// File: tb/tb_config_frame_loader.sv
// tb/tb_config_frame_loader.sv - directed self-checking bench for config_frame_loader
module tb_config_frame_loader;

  localparam logic [31:0] SYNC = 32'hFAB0_FAB1;

  logic         CLK = 1'b0;
  logic         resetn;
  logic [31:0]  s_data;
  logic         s_valid;
  logic         s_ready;
  logic [127:0] FrameData;
  logic [79:0]  FrameStrobe;
  logic         ConfigBusy;
  logic         ConfigError;

  int errors = 0;
  int checks = 0;

  config_frame_loader dut (
    .CLK(CLK), .resetn(resetn), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .FrameData(FrameData), .FrameStrobe(FrameStrobe), .ConfigBusy(ConfigBusy), .ConfigError(ConfigError)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic send(input logic [31:0] w);
    int n;
    n = 0;
    s_data  = w;
    s_valid = 1'b1;
    while (!s_ready && n < 50) begin
      step();
      n++;
    end
    if (!s_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: s_ready=%b required=1", s_ready);
    end
    step();
    s_valid = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; s_valid = 1'b0; s_data = '0;
    #3;
    checks++; if (FrameData !== 128'h0) begin errors++; $display("FAIL reset_data: got %h required 0", FrameData); end
    checks++; if (FrameStrobe !== 80'h0) begin errors++; $display("FAIL reset_strobe: got %h required 0", FrameStrobe); end
    checks++; if (ConfigBusy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", ConfigBusy); end
    checks++; if (ConfigError !== 1'b0) begin errors++; $display("FAIL reset_error: got %b required 0", ConfigError); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", s_ready); end
    step(); step();
    resetn = 1'b1;
    step();
  endtask

  task automatic test_garbage();
    send(32'hDEAD_BEEF);
    checks++; if (ConfigBusy !== 1'b0) begin errors++; $display("FAIL garbage_busy1: got %b required 0", ConfigBusy); end
    send(32'h0002_0005);
    step();
    checks++; if (ConfigBusy !== 1'b0) begin errors++; $display("FAIL garbage_busy2: got %b required 0", ConfigBusy); end
    checks++; if (FrameStrobe !== 80'h0) begin errors++; $display("FAIL garbage_strobe: got %h required 0", FrameStrobe); end
    checks++; if (FrameData !== 128'h0) begin errors++; $display("FAIL garbage_data: got %h required 0", FrameData); end
  endtask

  task automatic test_nominal();
    logic [79:0] exp_s;
    exp_s = '0; exp_s[45] = 1'b1;
    send(SYNC);
    checks++; if (ConfigBusy !== 1'b1) begin errors++; $display("FAIL nom_busy: got %b required 1", ConfigBusy); end
    send(32'h0002_0005);
    send(32'h1111_1111);
    send(32'h2222_2222);
    send(32'h3333_3333);
    checks++; if (FrameStrobe !== 80'h0) begin errors++; $display("FAIL nom_early_strobe: got %h required 0", FrameStrobe); end
    send(32'h4444_4444);
    checks++; if (FrameStrobe !== exp_s) begin errors++; $display("FAIL nom_strobe_c1: got %h required %h", FrameStrobe, exp_s); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL nom_ready_c1: got %b required 0", s_ready); end
    checks++; if (FrameData !== 128'h4444_4444_3333_3333_2222_2222_1111_1111) begin errors++; $display("FAIL nom_data: got %h required 44443333...1111", FrameData); end
    step();
    checks++; if (FrameStrobe !== exp_s) begin errors++; $display("FAIL nom_strobe_c2: got %h required %h", FrameStrobe, exp_s); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL nom_ready_c2: got %b required 0", s_ready); end
    step();
    checks++; if (FrameStrobe !== 80'h0) begin errors++; $display("FAIL nom_hold_strobe: got %h required 0", FrameStrobe); end
    checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL nom_ready_hold: got %b required 0", s_ready); end
    checks++; if (FrameData !== 128'h4444_4444_3333_3333_2222_2222_1111_1111) begin errors++; $display("FAIL nom_hold_data: got %h", FrameData); end
    step();
    checks++; if (s_ready !== 1'b1 || ConfigBusy !== 1'b1) begin errors++; $display("FAIL nom_header: ready=%b busy=%b required 1 1", s_ready, ConfigBusy); end
    send(32'h8000_0000);
    checks++; if (ConfigBusy !== 1'b0) begin errors++; $display("FAIL nom_end_idle: busy=%b required 0", ConfigBusy); end
  endtask

  task automatic test_out_of_range();
    send(SYNC);
    send(32'h0004_0000);
    checks++; if (ConfigError !== 1'b1) begin errors++; $display("FAIL oor_error: got %b required 1", ConfigError); end
    for (int k = 0; k < 4; k++) begin
      send(32'hA0A0_0000 + k);
      checks++; if (FrameStrobe !== 80'h0) begin errors++; $display("FAIL oor_strobe_%0d: got %h required 0", k, FrameStrobe); end
    end
    checks++; if (s_ready !== 1'b1 || ConfigBusy !== 1'b1) begin errors++; $display("FAIL oor_header: ready=%b busy=%b required 1 1", s_ready, ConfigBusy); end
    send(32'h8000_0000);
    checks++; if (ConfigBusy !== 1'b0 || ConfigError !== 1'b1) begin errors++; $display("FAIL oor_idle: busy=%b err=%b required 0 1", ConfigBusy, ConfigError); end
    send(SYNC);
    checks++; if (ConfigError !== 1'b0 || ConfigBusy !== 1'b1) begin errors++; $display("FAIL oor_clear: err=%b busy=%b required 0 1", ConfigError, ConfigBusy); end
    send(32'h8000_0000);
  endtask

  task automatic test_back_to_back();
    logic [31:0] words [0:10];
    int idx, cyc, h0, h1, s0_cnt, s79_cnt, other, s0_first, s79_first;
    logic rdy;
    words[0] = 32'h0000_0000;
    words[1] = 32'hC0C0_0001; words[2] = 32'hC0C0_0002; words[3] = 32'hC0C0_0003; words[4] = 32'hC0C0_0004;
    words[5] = 32'h0003_0013;
    words[6] = 32'hD0D0_0001; words[7] = 32'hD0D0_0002; words[8] = 32'hD0D0_0003; words[9] = 32'hD0D0_0004;
    words[10] = 32'h8000_0000;
    h0 = -1; h1 = -1; s0_cnt = 0; s79_cnt = 0; other = 0; s0_first = -1; s79_first = -1;
    send(SYNC);
    idx = 0; cyc = 0;
    while (idx < 11 && cyc < 100) begin
      rdy = s_ready;
      s_data = words[idx]; s_valid = 1'b1;
      step();
      if (rdy) begin
        if (idx == 0) h0 = cyc;
        if (idx == 5) h1 = cyc;
        idx++;
      end
      if (FrameStrobe[0]) begin s0_cnt++; if (s0_first < 0) s0_first = cyc; end
      if (FrameStrobe[79]) begin s79_cnt++; if (s79_first < 0) s79_first = cyc; end
      if ((FrameStrobe & ~(80'h1 | (80'h1 << 79))) != 80'h0) other++;
      cyc++;
    end
    s_valid = 1'b0;
    checks++; if (idx != 11) begin errors++; $display("FAIL b2b_timeout: words=%0d required 11", idx); end
    checks++; if (h1 - h0 != 8) begin errors++; $display("FAIL b2b_spacing: got %0d required 8", h1 - h0); end
    checks++; if (s0_cnt != 2) begin errors++; $display("FAIL b2b_s0_width: got %0d required 2", s0_cnt); end
    checks++; if (s79_cnt != 2) begin errors++; $display("FAIL b2b_s79_width: got %0d required 2", s79_cnt); end
    checks++; if (!(s0_first >= 0 && s79_first > s0_first)) begin errors++; $display("FAIL b2b_order: s0=%0d s79=%0d required s0<s79", s0_first, s79_first); end
    checks++; if (other != 0) begin errors++; $display("FAIL b2b_other: got %0d required 0", other); end
    checks++; if (FrameData !== 128'hD0D0_0004_D0D0_0003_D0D0_0002_D0D0_0001) begin errors++; $display("FAIL b2b_data: got %h", FrameData); end
    checks++; if (ConfigBusy !== 1'b0) begin errors++; $display("FAIL b2b_idle: busy=%b required 0", ConfigBusy); end
  endtask

  task automatic test_stalls();
    logic [127:0] exp_d;
    logic [79:0]  exp_s;
    logic [31:0]  rows [0:3];
    rows[0] = 32'h0123_4567; rows[1] = 32'h89AB_CDEF; rows[2] = 32'h5A5A_A5A5; rows[3] = 32'h0F0F_F0F0;
    exp_s = '0; exp_s[22] = 1'b1;
    exp_d = 128'hD0D0_0004_D0D0_0003_D0D0_0002_D0D0_0001;
    send(SYNC);
    send(32'h0001_0002);
    for (int k = 0; k < 4; k++) begin
      s_valid = 1'b0;
      s_data = 32'hBAD0_0000 + k;
      for (int j = 0; j <= k; j++) step();
      checks++; if (FrameData !== exp_d) begin errors++; $display("FAIL stall_hold_%0d: got %h required %h", k, FrameData, exp_d); end
      send(rows[k]);
      exp_d[k*32 +: 32] = rows[k];
      if (k < 3) begin
        checks++; if (FrameStrobe !== 80'h0) begin errors++; $display("FAIL stall_early_%0d: got %h required 0", k, FrameStrobe); end
      end
    end
    s_data = 32'hFFFF_FFFF; s_valid = 1'b1;
    checks++; if (FrameStrobe !== exp_s) begin errors++; $display("FAIL stall_strobe_c1: got %h required %h", FrameStrobe, exp_s); end
    step();
    s_data = 32'hEEEE_EEEE;
    checks++; if (FrameStrobe !== exp_s) begin errors++; $display("FAIL stall_strobe_c2: got %h required %h", FrameStrobe, exp_s); end
    step();
    s_data = 32'hDDDD_DDDD;
    checks++; if (FrameStrobe !== 80'h0) begin errors++; $display("FAIL stall_hold_strobe: got %h required 0", FrameStrobe); end
    step();
    s_valid = 1'b0;
    checks++; if (FrameData !== exp_d) begin errors++; $display("FAIL stall_data: got %h required %h", FrameData, exp_d); end
    checks++; if (s_ready !== 1'b1 || ConfigBusy !== 1'b1 || ConfigError !== 1'b0) begin errors++; $display("FAIL stall_header: ready=%b busy=%b err=%b required 1 1 0", s_ready, ConfigBusy, ConfigError); end
    send(32'h8000_0000);
  endtask

  task automatic test_reset_midstrobe();
    logic [79:0] exp_s;
    exp_s = '0; exp_s[1] = 1'b1;
    send(SYNC);
    send(32'h0000_0001);
    send(32'h1);
    send(32'h2);
    send(32'h3);
    send(32'h4);
    checks++; if (FrameStrobe !== exp_s) begin errors++; $display("FAIL rst_pre_strobe: got %h required %h", FrameStrobe, exp_s); end
    #1 resetn = 1'b0;
    #1;
    checks++; if (FrameStrobe !== 80'h0) begin errors++; $display("FAIL rst_strobe: got %h required 0", FrameStrobe); end
    checks++; if (FrameData !== 128'h0) begin errors++; $display("FAIL rst_data: got %h required 0", FrameData); end
    checks++; if (ConfigBusy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b required 0", ConfigBusy); end
    step();
    resetn = 1'b1;
    step();
    checks++; if (s_ready !== 1'b1 || ConfigBusy !== 1'b0) begin errors++; $display("FAIL rst_after: ready=%b busy=%b required 1 0", s_ready, ConfigBusy); end
  endtask

  initial begin
    test_reset();
    test_garbage();
    test_nominal();
    test_out_of_range();
    test_back_to_back();
    test_stalls();
    test_reset_midstrobe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/config_frame_loader.md
Name: config_frame_loader

Overview:
Upstream configuration stage feeding the per-tile frame-latch config memories. Accepts a 32-bit word stream over a valid/ready handshake and detects a sync word. Decodes a frame header, assembles one full frame of data across all rows on FrameData, then pulses exactly one FrameStrobe line so that the addressed column's frame latches capture it. Guarantees FrameData is stable before, during and after every strobe pulse, because the latches are level-sensitive.

Parameters:
FrameBitsPerRow, 32, data bits per row per frame (equals the word width)
MaxFramesPerCol, 20, frames per column; FrameStrobe lines per column
NumberOfRows, 4, rows per column; data words per frame
NumberOfCols, 4, columns addressed by the loader
StrobeCycles, 2, FrameStrobe high time in CLK cycles (must be ≥1)
SyncWord, 32'hFAB0_FAB1, stream start marker

Ports:
CLK  input  1  clock, rising edge
resetn  input  1  asynchronous active-low reset
s_data  input  32  stream word
s_valid  input  1  word valid
s_ready  output  1  loader can accept a word
FrameData  output  FrameBitsPerRow*NumberOfRows  frame data; row r occupies bits [r*32 +: 32]
FrameStrobe  output  MaxFramesPerCol*NumberOfCols  one-hot strobe; line index = col*MaxFramesPerCol + frame
ConfigBusy  output  1  high whenever state != IDLE
ConfigError  output  1  sticky out-of-range header flag

Behaviour:
- Reset: CLK and resetn (async active-low) as decided. While resetn is low, all of the following hold immediately, with no clock required:
  - state = IDLE
  - FrameData = 0
  - FrameStrobe = 0
  - ConfigBusy = 0
  - ConfigError = 0
  - row counter = 0
  - strobe counter = 0
- Transfer: a word is transferred on a CLK edge with s_valid && s_ready. s_ready is registered-state decoded: 1 in IDLE, HEADER and DATA; 0 in STROBE and HOLD.
- State IDLE:
  - A transferred word equal to SyncWord → HEADER, and ConfigError clears.
  - Any other word is consumed and discarded.
- State HEADER: transferred word decodes as end = s_data[31], col = s_data[23:16], frame = s_data[7:0].
  - end = 1 → IDLE; the other fields are ignored.
  - Otherwise col and frame are latched, the row counter is cleared, and the state goes to DATA.
  - If col ≥ NumberOfCols or frame ≥ MaxFramesPerCol, ConfigError sets and a skip flag is latched.
- State DATA:
  - Transfer k (k = 0..NumberOfRows-1) writes FrameData[k*32 +: 32]; all other rows hold.
  - On transfer of the last row: skip = 0 → STROBE; skip = 1 → HEADER, with no strobe.
- State STROBE:
  - FrameStrobe[col*MaxFramesPerCol+frame] is high for exactly StrobeCycles cycles, starting the cycle after the last data word is accepted.
  - All other strobe lines stay 0. FrameStrobe is registered and glitch-free.
  - Then → HOLD.
- State HOLD: one cycle with FrameStrobe = 0 and FrameData unchanged (latch hold margin), then → HEADER.
- FrameData changes only on DATA transfers. It holds its value after a strobe until the next frame's data arrives.
- Timing: the minimum cycles from header transfer to the next header acceptance is 1 + NumberOfRows + StrobeCycles + 1 (= 8 at defaults), with s_valid held high.
- s_valid low in any state stalls that state indefinitely, with no timeout; STROBE and HOLD proceed regardless of s_valid.
- Reset mid-frame, including mid-strobe: the strobe drops asynchronously. Partially loaded data is lost and FrameData is zeroed.
- The handshake does not depend on s_valid being held: s_data and s_valid may change freely while s_ready is 0.

Test Plan:
- Nominal frame:
  - Stimulus: SyncWord; header 32'h0002_0005; data 32'h1111_1111, 32'h2222_2222, 32'h3333_3333, 32'h4444_4444.
  - Required: FrameData = 128'h4444_4444_3333_3333_2222_2222_1111_1111; FrameStrobe[45] high for exactly 2 cycles, starting the cycle after the 4th data word; no other strobe bit ever set; s_ready = 0 for 3 cycles; then HEADER with s_ready = 1.
- Pre-sync garbage:
  - Stimulus: 32'hDEAD_BEEF and 32'h0002_0005 in IDLE.
  - Required: both consumed, ConfigBusy stays 0, no strobe, FrameData stays 0.
- Out-of-range header:
  - Stimulus: SyncWord; header 32'h0004_0000 (col 4); 4 data words.
  - Required: ConfigError = 1; FrameStrobe stays 0; returns to HEADER.
  - Follow-up: end header 32'h8000_0000 → IDLE with ConfigError still 1; a new SyncWord clears ConfigError.
- Back-to-back frames:
  - Stimulus: two frames (col 0 frame 0, then col 3 frame 19) with s_valid held high.
  - Required: FrameStrobe[0] pulse, then FrameStrobe[79] pulse; header-to-header spacing exactly 8 cycles.
- Stalls:
  - Stimulus: randomly deassert s_valid during DATA.
  - Required: FrameData rows fill only on transfers; strobe timing is relative to the last transfer; s_data changes while s_ready = 0 have no effect.
- Reset mid-strobe:
  - Stimulus: assert resetn = 0 in the first STROBE cycle.
  - Required: FrameStrobe, FrameData and ConfigBusy go to 0 immediately (asynchronously); after release, state is IDLE and s_ready = 1.
